cdc_fifo_rd_stream: RTL and testbench
=====================================

CDC_FIFO_RD_STREAM -- requirements
Module: cdc_fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning data word width, matching the FIFO's DW.
REQ-002 The block SHALL have parameter CNTW, default 16, meaning transfer counter width.
REQ-003 The block SHALL have port rd_clk, input, 1 bit: single clock, the read-side clock of the FIFO.
REQ-004 The block SHALL have port rd_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port fifo_rd_data, input, DW bits: FIFO head word, valid whenever fifo_rd_empty=0.
REQ-006 The block SHALL have port fifo_rd_empty, input, 1 bit: FIFO read-side empty flag.
REQ-007 The block SHALL have port fifo_rd_en, output, 1 bit: FIFO pop strobe.
REQ-008 The block SHALL have port out_data, output, DW bits: stream data.
REQ-009 The block SHALL have port out_valid, output, 1 bit: stream valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: stream ready from the consumer.
REQ-011 The block SHALL have port flush, input, 1 bit: synchronous discard of buffered words.
REQ-012 The block SHALL have port xfer_count, output, CNTW bits: count of completed stream handshakes.

Function
REQ-013 The block SHALL drain a first-word-fall-through FIFO read port into a valid/ready stream through a 2-entry skid buffer (head, tail).
REQ-014 The occupancy FSM SHALL have states EMPTY (0 words), ONE (1 word) and TWO (2 words); encoding SHALL be 2-bit binary.
REQ-015 fifo_rd_en SHALL equal rd_rst_n and not fifo_rd_empty and not flush and (state != TWO); it SHALL NOT depend combinationally on out_ready.
REQ-016 A pop SHALL capture fifo_rd_data into the head if the state is EMPTY, or if the state is ONE and the head is consumed in the same cycle; otherwise it SHALL capture into the tail.
REQ-017 A handshake occurs when out_valid=1 and out_ready=1; in state TWO a handshake SHALL move the tail into the head.
REQ-018 Transitions SHALL be (pop, handshake): EMPTY (1,x) -> ONE; ONE (1,0) -> TWO; ONE (0,1) -> EMPTY; ONE (1,1) -> ONE; TWO (x,1) -> ONE; all other combinations hold the state.
REQ-019 out_valid SHALL be 1 exactly when the state is ONE or TWO; out_data SHALL be the head register.
REQ-020 Latency from the FIFO becoming non-empty with the block in EMPTY to out_valid=1 SHALL be 1 cycle.
REQ-021 With out_ready held at 1 and the FIFO non-empty, throughput SHALL be 1 word per cycle.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable.
REQ-023 Words SHALL be delivered in FIFO order with none lost or duplicated.
REQ-024 xfer_count SHALL increment by 1 per handshake and wrap from 2^CNTW-1 to 0.
REQ-025 When flush=1, the next state SHALL be EMPTY and no pop SHALL occur; a handshake in the same cycle SHALL still be counted.
REQ-026 flush SHALL NOT clear xfer_count.
REQ-027 When fifo_rd_empty=1, no pop SHALL occur and the buffered words SHALL continue to drain normally.

Reset
REQ-028 While rd_rst_n=0 at a rising edge of rd_clk, the block SHALL load: state=EMPTY, out_valid=0, head=0, tail=0, out_data=0, xfer_count=0.
REQ-029 fifo_rd_en SHALL be 0 during reset.
REQ-030 A reset asserted mid-stream SHALL discard the buffered words; the FIFO read-side reset is the integrator's responsibility.

Structure
REQ-031 The FSM state encoding constants (EMPTY=0, ONE=1, TWO=2) SHALL reside in the shared cdc package alongside the other cdc_* definitions.
REQ-032 The block SHALL be implemented as a single module with no sub-modules; the skid buffer SHALL be inline.
REQ-033 The block SHALL contain no combinational path from out_ready to fifo_rd_en.

Verification
REQ-034 Reset then idle: with rd_rst_n=0 for 2 cycles and the FIFO empty, out_valid=0, fifo_rd_en=0 and xfer_count=0 SHALL hold.
REQ-035 Streaming: push 8 words 0xA0..0xA7 with out_ready=1; the block SHALL deliver 0xA0..0xA7 on 8 consecutive cycles, the first 1 cycle after not-empty, ending with xfer_count=8.
REQ-036 Backpressure: 4 words queued with out_ready=0; the state SHALL reach TWO, fifo_rd_en SHALL drop, and out_data SHALL hold 0xA0; after out_ready=1 the order SHALL be 0xA0..0xA3 with no gaps.
REQ-037 Flush in TWO with out_ready=1: the head SHALL be counted (xfer_count +1), out_valid=0 the next cycle, the tail SHALL be dropped, and no pop SHALL occur in the flush cycle.
REQ-038 Wrap: CNTW=4 with 17 handshakes SHALL give xfer_count=1.
REQ-039 Reset mid-stream in state TWO: the next cycle SHALL give out_valid=0, state EMPTY and xfer_count=0.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing FIFO blocks.
// The read-side stream adapter uses the occupancy states declared here.
package cdc_pkg;

    typedef enum logic [1:0] {
        CDC_EMPTY = 2'd0,
        CDC_ONE   = 2'd1,
        CDC_TWO   = 2'd2
    } cdc_rd_state_e;

endpackage

// File: rtl/cdc_fifo_rd_stream.sv
// Drains a first-word-fall-through FIFO read port into a valid/ready stream
// through a two-entry skid buffer, counting completed stream handshakes.
import cdc_pkg::*;

module cdc_fifo_rd_stream #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            rd_clk,
    input  logic            rd_rst_n,
    input  logic [DW-1:0]   fifo_rd_data,
    input  logic            fifo_rd_empty,
    output logic            fifo_rd_en,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    output logic [CNTW-1:0] xfer_count
);

    cdc_rd_state_e   state_q, state_d;
    logic [DW-1:0]   head_q, head_d;
    logic [DW-1:0]   tail_q, tail_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            pop;
    logic            hs;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_q <= CDC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        // Pop depends only on registered occupancy, never on out_ready.
        pop     = rd_rst_n && !fifo_rd_empty && !flush && (state_q != CDC_TWO);
        hs      = (state_q != CDC_EMPTY) && out_ready;

        if (hs) begin
            cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
        end

        case (state_q)
            CDC_EMPTY: begin
                if (pop) begin
                    head_d  = fifo_rd_data;
                    state_d = CDC_ONE;
                end
            end
            CDC_ONE: begin
                if (pop && hs) begin
                    head_d = fifo_rd_data;
                end else if (pop) begin
                    tail_d  = fifo_rd_data;
                    state_d = CDC_TWO;
                end else if (hs) begin
                    state_d = CDC_EMPTY;
                end
            end
            CDC_TWO: begin
                if (hs) begin
                    head_d  = tail_q;
                    state_d = CDC_ONE;
                end
            end
            default: state_d = CDC_EMPTY;
        endcase

        // A flushed cycle still counts its handshake but keeps no words.
        if (flush) begin
            state_d = CDC_EMPTY;
        end

        fifo_rd_en = pop;
        out_valid  = (state_q != CDC_EMPTY);
        out_data   = head_q;
        xfer_count = cnt_q;
    end

endmodule

// File: tb/tb_cdc_fifo_rd_stream.sv
// Scoreboard bench: a queue-based FWFT FIFO model feeds the block, expected
// words are queued on push and checked by a monitor at each stream handshake.
import cdc_pkg::*;

module tb_cdc_fifo_rd_stream;

    logic        clk;
    logic        rd_rst_n;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic        fifo_rd_en;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [15:0] xfer_count;

    logic        fifo_rd_en4;
    logic [31:0] out_data4;
    logic        out_valid4;
    logic [3:0]  xfer_count4;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    cdc_fifo_rd_stream #(.DW(32), .CNTW(16)) dut (
        .rd_clk(clk), .rd_rst_n(rd_rst_n),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .xfer_count(xfer_count)
    );

    // Narrow-counter copy sharing the same inputs, used for the wrap check.
    cdc_fifo_rd_stream #(.DW(32), .CNTW(4)) dut4 (
        .rd_clk(clk), .rd_rst_n(rd_rst_n),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_en(fifo_rd_en4), .out_data(out_data4), .out_valid(out_valid4),
        .out_ready(out_ready), .flush(flush), .xfer_count(xfer_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_rd_empty = (fifo_q.size() == 0);
        fifo_rd_data  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    endtask

    task automatic push(input logic [31:0] w, input bit expect_out);
        fifo_q.push_back(w);
        if (expect_out) exp_q.push_back(w);
        refresh();
    endtask

    // One clock: note whether a pop is requested, cross the edge, update the FIFO model.
    task automatic cyc();
        logic en;
        #1;
        en = fifo_rd_en;
        @(posedge clk);
        @(negedge clk);
        if (en && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh();
    endtask

    // Monitor: compare every handshake against the head of the expected queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (out_valid && out_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL stream_word: got %0h expected %0h", out_data, e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rd_rst_n  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        refresh();
        @(negedge clk);

        // Reset then idle.
        cyc();
        cyc();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        chk("rst_count", 64'(xfer_count), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        push(32'h55, 1'b0);
        #1;
        chk("rst_rd_en_nonempty", 64'(fifo_rd_en), 64'd0);
        fifo_q.delete();
        refresh();
        rd_rst_n = 1'b1;
        cyc();
        chk("idle_valid", 64'(out_valid), 64'd0);

        // Streaming at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(32'hA0 + 32'(i), 1'b1);
        cyc();
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 64'(out_valid), 64'd1);
            chk("stream_data", 64'(out_data), 64'hA0 + 64'(i));
            cyc();
        end
        chk("stream_end_valid", 64'(out_valid), 64'd0);
        chk("stream_count", 64'(xfer_count), 64'd8);

        // Backpressure fills the skid buffer.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_data", 64'(out_data), 64'hA0);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        chk("bp_state_two", 64'(dut.state_q), 64'(CDC_TWO));
        chk("bp_rd_en_low", 64'(fifo_rd_en), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_rd_en_ready", 64'(fifo_rd_en), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_drain_valid", 64'(out_valid), 64'd1);
            chk("bp_drain_data", 64'(out_data), 64'hA0 + 64'(i));
            cyc();
        end
        chk("bp_end_valid", 64'(out_valid), 64'd0);
        chk("bp_count", 64'(xfer_count), 64'd12);

        // Flush in TWO with a simultaneous handshake.
        out_ready = 1'b0;
        push(32'hB0, 1'b1);
        push(32'hB1, 1'b1);
        push(32'hB2, 1'b1);
        cyc();
        cyc();
        chk("fl_state_two", 64'(dut.state_q), 64'(CDC_TWO));
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        chk("fl_no_pop", 64'(fifo_rd_en), 64'd0);
        cyc();
        flush = 1'b0;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_count", 64'(xfer_count), 64'd13);
        chk("fl_fifo_left", 64'(fifo_q.size()), 64'd1);
        if (exp_q.size() > 0) exp_q.delete(0);
        cyc();
        chk("fl_after_data", 64'(out_data), 64'hB2);
        cyc();
        chk("fl_after_count", 64'(xfer_count), 64'd14);

        // Reset in the middle of a stalled stream.
        out_ready = 1'b0;
        push(32'hC0, 1'b1);
        push(32'hC1, 1'b1);
        push(32'hC2, 1'b1);
        cyc();
        cyc();
        chk("mr_state_two", 64'(dut.state_q), 64'(CDC_TWO));
        rd_rst_n = 1'b0;
        cyc();
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_state", 64'(dut.state_q), 64'(CDC_EMPTY));
        chk("mr_count", 64'(xfer_count), 64'd0);
        fifo_q.delete();
        exp_q.delete();
        refresh();
        rd_rst_n = 1'b1;
        cyc();

        // Counter wrap on the 4-bit instance.
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(32'h10 + 32'(i), 1'b1);
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            cyc();
            n++;
        end
        chk("wrap_drained", 64'(exp_q.size()), 64'd0);
        chk("wrap_count4", 64'(xfer_count4), 64'd1);
        chk("wrap_count16", 64'(xfer_count), 64'd17);
        cyc();
        chk("wrap_idle_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
